jk_updown_counter: RTL and testbench

JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

---
 rtl/jk_pkg.sv | 14 +
 rtl/jk_cell.sv | 24 ++
 rtl/jk_updown_counter.sv | 86 ++++++++
 tb/tb_jk_updown_counter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK-cell based up/down counter.
package jk_pkg;

  localparam int unsigned JK_DEFAULT_WIDTH = 4;

  // Per-bit JK command, ordered {J,K}.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = (j & ~q_q) | (~k & q_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-(MAX+1) up/down counter with parallel load, built from JK cells.
module jk_updown_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = JK_DEFAULT_WIDTH,
  parameter int unsigned MAX   = (2 ** WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] step_mask;
  logic             use_tgt;
  logic             wrap_q;

  // Loads and wraps force a constant (J=bit, K=~bit); ordinary steps toggle
  // exactly the bits that differ between cnt and cnt+/-1.
  always_comb begin
    j_d       = '0;
    k_d       = '0;
    tgt       = '0;
    step_mask = '0;
    use_tgt   = 1'b0;
    if (load) begin
      use_tgt = 1'b1;
      tgt     = (din > MAX_V) ? MAX_V : din;
    end else if (en) begin
      if (cnt > MAX_V) begin
        use_tgt = 1'b1;
        tgt     = '0;
      end else if (up) begin
        if (cnt == MAX_V) begin
          use_tgt = 1'b1;
          tgt     = '0;
        end else begin
          step_mask = cnt ^ (cnt + WIDTH'(1));
        end
      end else begin
        if (cnt == '0) begin
          use_tgt = 1'b1;
          tgt     = MAX_V;
        end else begin
          step_mask = cnt ^ (cnt - WIDTH'(1));
        end
      end
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (use_tgt) {j_d[i], k_d[i]} = tgt[i] ? JK_SET : JK_RST;
      else         {j_d[i], k_d[i]} = step_mask[i] ? JK_TGL : JK_HOLD;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_d[g]),
      .k   (k_d[g]),
      .q   (cnt[g])
    );
  end

  assign tc = en & ~load & ((up & (cnt == MAX_V)) | (~up & (cnt == '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= tc;
  end

  assign q    = cnt;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Scoreboard bench for jk_updown_counter (WIDTH=4, MAX=9).
module tb_jk_updown_counter;

  localparam int unsigned W  = 4;
  localparam int unsigned MX = 9;

  typedef struct {
    string      tag;
    logic       tc;
    logic [3:0] q;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b0, load = 1'b0;
  logic [3:0] din = '0;
  logic [3:0] q;
  logic       tc, wrap;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   mq = 0;
  logic mw = 1'b0;
  logic stim_done = 1'b0;

  jk_updown_counter #(.WIDTH(W), .MAX(MX)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .din  (din),
    .q    (q),
    .tc   (tc),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference behaviour in plain integer arithmetic.
  task automatic step(input logic r, input logic e, input logic u,
                      input logic l, input int d, input string tag);
    exp_t x;
    int   nq;
    logic ntc;
    @(negedge clk);
    rst = r; en = e; up = u; load = l; din = 4'(d);
    if (r) mq = 0;
    ntc = e && !l && ((u && mq == MX) || (!u && mq == 0));
    if (r)         nq = 0;
    else if (l)    nq = (d > MX) ? MX : d;
    else if (e)    nq = u ? ((mq >= MX) ? 0 : mq + 1)
                          : ((mq == 0) ? MX : ((mq > MX) ? 0 : mq - 1));
    else           nq = mq;
    x.tag  = tag;
    x.tc   = ntc;
    x.q    = 4'(nq);
    x.wrap = r ? 1'b0 : ntc;
    sb.push_back(x);
    mq = nq;
    mw = x.wrap;
    @(posedge clk);
  endtask

  // Monitor: tc sampled mid-cycle, q/wrap just after the edge.
  initial begin : monitor
    logic tc_s;
    exp_t x;
    forever begin
      @(negedge clk);
      #3 tc_s = tc;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check({x.tag, ".tc"},   int'(tc_s), int'(x.tc));
        check({x.tag, ".q"},    int'(q),    int'(x.q));
        check({x.tag, ".wrap"}, int'(wrap), int'(x.wrap));
      end
    end
  end

  initial begin : stimulus
    int cyc;
    #3;
    check("reset.q", int'(q), 0);
    check("reset.wrap", int'(wrap), 0);
    check("reset.tc", int'(tc), 0);

    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, "count_up");

    step(0, 0, 1, 1, 0, "load0");
    step(0, 1, 0, 0, 0, "down_wrap");
    step(0, 0, 0, 0, 0, "after_down_wrap");
    step(0, 0, 0, 0, 0, "idle");

    step(0, 0, 1, 1, 5, "load5");
    step(0, 1, 1, 1, 13, "load_clamp");
    step(0, 1, 1, 0, 0, "up_wrap_after_clamp");
    step(0, 0, 1, 0, 0, "wrap_pulse_end");

    step(0, 0, 1, 1, 9, "load9");
    step(0, 1, 1, 1, 3, "load_over_tc");
    step(0, 0, 1, 0, 0, "no_wrap_after_load");

    step(0, 0, 1, 1, 7, "load7");
    #2;
    load = 1'b0; en = 1'b1; up = 1'b1;
    rst = 1'b1;
    #1;
    check("async_rst.q", int'(q), 0);
    check("async_rst.wrap", int'(wrap), 0);
    check("async_rst.tc", int'(tc), 0);
    mq = 0; mw = 1'b0;
    step(1, 1, 1, 0, 0, "hold_in_rst");
    step(1, 1, 0, 0, 0, "hold_in_rst_dn");
    step(0, 1, 1, 0, 0, "first_after_rst");

    step(0, 0, 1, 1, 4, "load4");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, "en_off_hold");
    step(0, 1, 1, 0, 0, "alt_up");
    step(0, 1, 0, 0, 0, "alt_dn");
    step(0, 1, 1, 0, 0, "alt_up2");

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 15)), "random");
    end
    step(0, 0, 1, 0, 0, "final_idle");

    cyc = 0;
    while (sb.size() > 0 && cyc < 10) begin
      @(posedge clk);
      cyc++;
    end
    #2;
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
